axis_uart_tx_arbiter: RTL

Round-robin arbiter that shares one AXI-Stream byte sink, normally the UART transmit path, between `NUM_SRC` AXI-Stream byte sources. A grant is held for one whole packet, which ends at `tlast` or after `MAX_WORDS` beats, so bytes from different sources never interleave on the serial line. The block sits between the per-client streams and the single `AXIS_to_UART_TX` instance in the top level.

---
 rtl/axis_uart_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 21 ++
 rtl/axis_uart_tx_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/axis_uart_pkg.sv
// axis_uart_pkg: shared state enum, header marker and round-robin pick helper
package axis_uart_pkg;

    typedef enum logic [1:0] {IDLE, HEADER, PASS} arb_state_t;

    localparam logic [7:0] ARB_HDR_MARK = 8'hA0;

    // First requester after 'last' in circular order over n sources (n in 2..16);
    // scanning from the far end lets the closest hit overwrite earlier ones.
    function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] last, input int n);
        logic [3:0] r;
        int j;
        r = last;
        for (int i = 16; i >= 1; i--) begin
            j = (int'(last) + i) % n;
            if (i <= n && req[j]) r = j[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin priority picker
module rr_arbiter
    import axis_uart_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] last,
    output logic [$clog2(NUM_SRC)-1:0] idx,
    output logic                       any
);

    localparam int W = $clog2(NUM_SRC);

    // Pick the next requester after the previous winner
    always_comb begin
        any = |req;
        idx = W'(rr_pick(16'(req), 4'(last), NUM_SRC));
    end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// axis_uart_tx_arbiter: packet-granular round-robin mux of AXIS byte sources onto one UART TX sink.
// Define AXIS_UART_ARB_HEADER_EN to prefix each grant with an 8'hA0|grant_id header byte.
module axis_uart_tx_arbiter
    import axis_uart_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int MAX_WORDS = 64
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [NUM_SRC*8-1:0]       s_tdata,
    input  logic [NUM_SRC-1:0]         s_tvalid,
    input  logic [NUM_SRC-1:0]         s_tlast,
    output logic [NUM_SRC-1:0]         s_tready,
    output logic [7:0]                 m_tdata,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy
);

    localparam int W = $clog2(NUM_SRC);

    arb_state_t state_q, state_d;
    logic [W-1:0] grant_q, grant_d, last_q, last_d, pick;
    logic [7:0]   cnt_q, cnt_d;
    logic         any;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .req  (s_tvalid),
        .last (last_q),
        .idx  (pick),
        .any  (any)
    );

    assign grant_id = grant_q;
    assign busy     = state_q != IDLE;

    // State, grant and beat counter registers; last_grant starts at the top so source 0 wins first
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= W'(NUM_SRC - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and the combinational output mux
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        m_tvalid = 1'b0;
        m_tdata  = 8'h00;
        m_tlast  = 1'b0;
        s_tready = '0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d = pick;
                    last_d  = pick;
                    cnt_d   = '0;
`ifdef AXIS_UART_ARB_HEADER_EN
                    state_d = HEADER;
`else
                    state_d = PASS;
`endif
                end
            end
`ifdef AXIS_UART_ARB_HEADER_EN
            HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = ARB_HDR_MARK | 8'(grant_q);
                state_d  = m_tready ? PASS : HEADER;
            end
`endif
            PASS: begin
                m_tvalid = s_tvalid[grant_q];
                m_tdata  = s_tdata[{grant_q, 3'b000} +: 8];
                m_tlast  = s_tlast[grant_q] | (cnt_q == 8'(MAX_WORDS - 1));
                s_tready = m_tready ? NUM_SRC'(1) << grant_q : '0;
                if (s_tvalid[grant_q] && m_tready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = m_tlast ? IDLE : PASS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
